frame_accumulator: RTL and testbench

FRAME_ACCUMULATOR -- requirements
Module: frame_accumulator

---
 rtl/frame_accumulator.sv | 95 +++++++++
 tb/tb_frame_accumulator.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_accumulator.sv
// Frame accumulator: pulls FRAME_LEN words from an upstream get-method port,
// presents sum/max/first of each frame, and flags breaks in the STEP sequence.
module frame_accumulator #(
    parameter int WIDTH     = 32,
    parameter int FRAME_LEN = 6,
    parameter int STEP      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   get_data,
    input  logic               RDY_get,
    output logic               EN_get,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH+7:0]   res_sum,
    output logic [WIDTH-1:0]   res_max,
    output logic [WIDTH-1:0]   res_first,
    output logic [15:0]        frame_cnt,
    output logic               seq_err
);

    typedef enum logic {ACC, HOLD} state_t;

    localparam logic [7:0]       LAST_IDX = 8'(FRAME_LEN - 1);
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

    state_t           state;
    logic [7:0]       idx;
    logic [WIDTH+7:0] acc_sum;
    logic [WIDTH-1:0] acc_max;
    logic [WIDTH-1:0] acc_first;
    logic [WIDTH-1:0] prev_word;
    logic             prev_valid;

    logic [WIDTH+7:0] sum_next;
    logic [WIDTH-1:0] max_next;
    logic [WIDTH-1:0] first_next;

    always_comb begin
        EN_get = RDY_get & reset & (state == ACC);
    end

    // Running values including the word on get_data, used both to advance the
    // accumulators and to load the result on the last word of a frame.
    always_comb begin
        sum_next   = acc_sum + {8'b0, get_data};
        max_next   = ((idx == 8'd0) || (get_data > acc_max)) ? get_data : acc_max;
        first_next = (idx == 8'd0) ? get_data : acc_first;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ACC;
            idx        <= '0;
            acc_sum    <= '0;
            acc_max    <= '0;
            acc_first  <= '0;
            prev_word  <= '0;
            prev_valid <= 1'b0;
            res_valid  <= 1'b0;
            res_sum    <= '0;
            res_max    <= '0;
            res_first  <= '0;
            frame_cnt  <= '0;
            seq_err    <= 1'b0;
        end else if (EN_get) begin
            prev_word  <= get_data;
            prev_valid <= 1'b1;
            if (prev_valid && (get_data != prev_word + STEP_W))
                seq_err <= 1'b1;
            // Accumulators are cleared on entry to HOLD so ACC restarts clean.
            if (idx == LAST_IDX) begin
                res_sum   <= sum_next;
                res_max   <= max_next;
                res_first <= first_next;
                res_valid <= 1'b1;
                state     <= HOLD;
                idx       <= '0;
                acc_sum   <= '0;
                acc_max   <= '0;
                acc_first <= '0;
            end else begin
                acc_sum   <= sum_next;
                acc_max   <= max_next;
                acc_first <= first_next;
                idx       <= idx + 8'd1;
            end
        end else if (state == HOLD && res_ready) begin
            state     <= ACC;
            res_valid <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_frame_accumulator.sv
// Self-checking bench for frame_accumulator: vector table, directed corner
// sequences and a randomized run against a queue-based frame model.
module tb_frame_accumulator;

    localparam int W  = 32;
    localparam int FL = 6;
    localparam int ST = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [W-1:0]   get_data = '0;
    logic           RDY_get = 1'b0;
    logic           res_ready = 1'b0;
    logic           EN_get;
    logic           res_valid;
    logic [W+7:0]   res_sum;
    logic [W-1:0]   res_max;
    logic [W-1:0]   res_first;
    logic [15:0]    frame_cnt;
    logic           seq_err;

    always #5 clk = ~clk;

    frame_accumulator #(.WIDTH(W), .FRAME_LEN(FL), .STEP(ST)) dut (
        .clk(clk), .reset(reset), .get_data(get_data), .RDY_get(RDY_get),
        .EN_get(EN_get), .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_max(res_max), .res_first(res_first),
        .frame_cnt(frame_cnt), .seq_err(seq_err)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: words of the open frame, presented result, sequence state
    logic [W-1:0] cur[$];
    logic [W+7:0] sums[$];
    bit           m_hold = 1'b0, m_pv = 1'b0, m_err = 1'b0;
    logic [W-1:0] m_prev = '0, m_max = '0, m_first = '0;
    logic [W+7:0] m_sum = '0;
    logic [15:0]  m_cnt = '0;
    bit           last_xfer = 1'b0;
    logic [W-1:0] last_word = '0;

    typedef struct {
        logic [W-1:0] start;
        int           bump_at;
        int           hold;
        logic [W+7:0] e_sum;
        logic [W-1:0] e_max;
        logic [W-1:0] e_first;
        bit           e_err;
    } vec_t;
    vec_t vt[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        bit xfer;
        #1;
        xfer = reset && RDY_get && !m_hold;
        chk("en_get", 64'(EN_get), 64'(xfer));
        last_xfer = xfer;
        last_word = get_data;
        if (!reset) begin
            cur.delete();
            m_hold = 0; m_pv = 0; m_err = 0; m_cnt = '0;
            m_sum = '0; m_max = '0; m_first = '0;
        end else if (xfer) begin
            if (m_pv && get_data != m_prev + W'(ST)) m_err = 1;
            m_pv = 1;
            m_prev = get_data;
            cur.push_back(get_data);
            if (cur.size() == FL) begin
                m_sum = '0;
                m_max = '0;
                foreach (cur[i]) begin
                    m_sum += {8'b0, cur[i]};
                    if (cur[i] > m_max) m_max = cur[i];
                end
                m_first = cur[0];
                cur.delete();
                m_hold = 1;
                sums.push_back(m_sum);
            end
        end else if (m_hold && res_ready) begin
            m_hold = 0;
            m_cnt++;
        end
        @(posedge clk);
        #1;
        chk("res_valid", 64'(res_valid), 64'(m_hold));
        chk("seq_err", 64'(seq_err), 64'(m_err));
        chk("frame_cnt", 64'(frame_cnt), 64'(m_cnt));
        if (m_hold) begin
            chk("res_sum", 64'(res_sum), 64'(m_sum));
            chk("res_max", 64'(res_max), 64'(m_max));
            chk("res_first", 64'(res_first), 64'(m_first));
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; RDY_get = 1'b1; res_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1; RDY_get = 1'b0;
    endtask

    logic [W-1:0] nxt;
    int k;

    initial begin
        vt[0] = '{start: 32'd0,          bump_at: 6, hold: 0, e_sum: 40'd60,
                  e_max: 32'd20,         e_first: 32'd0,          e_err: 1'b0};
        vt[1] = '{start: 32'd24,         bump_at: 6, hold: 3, e_sum: 40'd204,
                  e_max: 32'd44,         e_first: 32'd24,         e_err: 1'b0};
        vt[2] = '{start: 32'd0,          bump_at: 2, hold: 1, e_sum: 40'd64,
                  e_max: 32'd21,         e_first: 32'd0,          e_err: 1'b1};
        vt[3] = '{start: 32'hFFFF_FFF0,  bump_at: 6, hold: 2, e_sum: 40'h3_FFFF_FFDC,
                  e_max: 32'hFFFF_FFFC,  e_first: 32'hFFFF_FFF0,  e_err: 1'b0};
        vt[4] = '{start: 32'd100,        bump_at: 6, hold: 0, e_sum: 40'd660,
                  e_max: 32'd120,        e_first: 32'd100,        e_err: 1'b0};

        // Reset state, with RDY_get high to show EN_get is gated by reset
        do_reset();
        chk("rst_valid", 64'(res_valid), 64'd0);
        chk("rst_sum", 64'(res_sum), 64'd0);
        chk("rst_max", 64'(res_max), 64'd0);
        chk("rst_first", 64'(res_first), 64'd0);
        chk("rst_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_err", 64'(seq_err), 64'd0);

        // Vector table: one frame per entry, held for a number of cycles
        for (int t = 0; t < 5; t++) begin
            do_reset();
            for (int i = 0; i < FL; i++) begin
                get_data = vt[t].start + W'(i * ST) + ((i >= vt[t].bump_at) ? 32'd1 : 32'd0);
                RDY_get = 1'b1;
                tick();
            end
            get_data = get_data + W'(ST);
            chk("tbl_valid", 64'(res_valid), 64'd1);
            chk("tbl_sum", 64'(res_sum), 64'(vt[t].e_sum));
            chk("tbl_max", 64'(res_max), 64'(vt[t].e_max));
            chk("tbl_first", 64'(res_first), 64'(vt[t].e_first));
            chk("tbl_err", 64'(seq_err), 64'(vt[t].e_err));
            for (int h = 0; h < vt[t].hold; h++) begin
                tick();
                chk("tbl_hold_sum", 64'(res_sum), 64'(vt[t].e_sum));
                chk("tbl_hold_valid", 64'(res_valid), 64'd1);
            end
            res_ready = 1'b1;
            tick();
            chk("tbl_handoff_valid", 64'(res_valid), 64'd0);
            chk("tbl_handoff_cnt", 64'(frame_cnt), 64'd1);
            res_ready = 1'b0;
            RDY_get = 1'b0;
        end

        // Sequence error timing: flag appears right after word 9 and sticks
        do_reset();
        RDY_get = 1'b1;
        get_data = 32'd0; tick();
        get_data = 32'd4; tick();
        chk("seq_before", 64'(seq_err), 64'd0);
        get_data = 32'd9; tick();
        chk("seq_after", 64'(seq_err), 64'd1);
        get_data = 32'd13; tick();
        get_data = 32'd17; tick();
        get_data = 32'd21; tick();
        chk("seq_sum", 64'(res_sum), 64'd64);
        chk("seq_max", 64'(res_max), 64'd21);
        res_ready = 1'b1; RDY_get = 1'b0;
        tick();
        chk("seq_sticky", 64'(seq_err), 64'd1);

        // Random RDY_get gaps over two back-to-back frames 0..44
        do_reset();
        res_ready = 1'b1;
        sums.delete();
        k = 0;
        for (int c = 0; c < 300 && k < 12; c++) begin
            RDY_get = 1'($urandom_range(0, 1));
            get_data = W'(k * ST);
            tick();
            if (last_xfer) k++;
        end
        chk("gap_words", 64'(k), 64'd12);
        RDY_get = 1'b0;
        tick();
        tick();
        chk("gap_results", 64'(sums.size()), 64'd2);
        if (sums.size() == 2) begin
            chk("gap_sum0", 64'(sums[0]), 64'd60);
            chk("gap_sum1", 64'(sums[1]), 64'd204);
        end
        chk("gap_cnt", 64'(frame_cnt), 64'd2);
        chk("gap_err", 64'(seq_err), 64'd0);

        // Reset mid-frame discards the partial frame
        do_reset();
        RDY_get = 1'b1;
        for (int i = 0; i < 3; i++) begin
            get_data = W'(i * ST);
            tick();
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < FL; i++) begin
            chk("mid_novalid", 64'(res_valid), 64'd0);
            get_data = W'(i * ST);
            tick();
        end
        chk("mid_sum", 64'(res_sum), 64'd60);
        res_ready = 1'b1; RDY_get = 1'b0;
        tick();
        chk("mid_cnt", 64'(frame_cnt), 64'd1);

        // Reset while holding a result drops it
        do_reset();
        RDY_get = 1'b1;
        for (int i = 0; i < FL; i++) begin
            get_data = W'(i * ST);
            tick();
        end
        chk("hold_pre", 64'(res_valid), 64'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1; RDY_get = 1'b0;
        tick();
        chk("hold_drop_valid", 64'(res_valid), 64'd0);
        chk("hold_drop_cnt", 64'(frame_cnt), 64'd0);

        // Randomized run with occasional resets and late sequence breaks
        do_reset();
        nxt = W'($urandom);
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) != 0);
            RDY_get = 1'($urandom_range(0, 1));
            res_ready = ($urandom_range(0, 2) != 0);
            if (c > 1500 && $urandom_range(0, 63) == 0) get_data = W'($urandom);
            else get_data = nxt;
            tick();
            if (last_xfer) nxt = last_word + W'(ST);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
